// File: rtl/controlador_compra_if.sv
// Bus between the checkout sequencer, the scale front panel and the price/weight accumulator.
// The slave modport is the sequencer's view; master is the environment driving it.
interface controlador_compra_if #(
  parameter int W  = 11,
  parameter int IW = 4
);
  logic [W-1:0]  peso_balanca;
  logic [W-1:0]  preco_unitario;
  logic          pedido_taxa;
  logic          pedido_fim;
  logic          anular;
  logic          emissao_talao;
  logic [W-1:0]  preco_produto;
  logic [W-1:0]  peso_produto;
  logic          subtrair;
  logic          taxa;
  logic          fim_compra;
  logic          limpar;
  logic [IW-1:0] num_itens;
  logic          erro;

  modport master (
    output peso_balanca, preco_unitario, pedido_taxa, pedido_fim, anular, emissao_talao,
    input  preco_produto, peso_produto, subtrair, taxa, fim_compra, limpar, num_itens, erro
  );

  modport slave (
    input  peso_balanca, preco_unitario, pedido_taxa, pedido_fim, anular, emissao_talao,
    output preco_produto, peso_produto, subtrair, taxa, fim_compra, limpar, num_itens, erro
  );
endinterface

// File: rtl/controlador_compra.sv
// Checkout sequencer: debounces the scale, registers one item per stable weight, runs the
// fee/finish/receipt/clear handshake. Define ANULAR_ITEM_EN to enable single-level item undo.
module controlador_compra #(
  parameter int W              = 11,
  parameter int ESTAVEL_CICLOS = 4,
  parameter int MAX_ITENS      = 15,
  parameter int IW             = 4,
  parameter int TALAO_TIMEOUT  = 16
) (
  input logic                 clk,
  input logic                 rst,
  controlador_compra_if.slave bus
);

  localparam int CW = $clog2(ESTAVEL_CICLOS + 1);
  localparam int TW = $clog2(TALAO_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ESPERA, PESAGEM, REGISTO, RETIRADA, TAXA, FIM, LIMPEZA
  } estado_t;

  estado_t       estado, estado_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] timer, timer_n;
  logic [W-1:0]  amostra, amostra_n;
  logic [W-1:0]  item_preco, item_preco_n;
  logic [W-1:0]  item_peso, item_peso_n;
  logic          taxa_lat, taxa_lat_n;

  logic [W-1:0]  preco_q, preco_n;
  logic [W-1:0]  peso_q, peso_n;
  logic          subtrair_q, subtrair_n;
  logic          taxa_q, taxa_n;
  logic          fim_q, fim_n;
  logic          limpar_q, limpar_n;
  logic [IW-1:0] num_q, num_n;
  logic          erro_q, erro_n;

`ifdef ANULAR_ITEM_EN
  logic [W-1:0]  last_preco, last_preco_n;
  logic [W-1:0]  last_peso, last_peso_n;
  logic          undo_ok, undo_ok_n;
`else
  logic          unused_anular;
  assign unused_anular = bus.anular;
`endif

  // Every register is a next-state function of the current state, so outputs are fully registered.
  always_comb begin
    estado_n     = estado;
    cnt_n        = cnt;
    timer_n      = timer;
    amostra_n    = amostra;
    item_preco_n = item_preco;
    item_peso_n  = item_peso;
    taxa_lat_n   = taxa_lat;
    preco_n      = '0;
    peso_n       = '0;
    subtrair_n   = 1'b0;
    taxa_n       = taxa_q;
    fim_n        = 1'b0;
    limpar_n     = 1'b0;
    num_n        = num_q;
    erro_n       = erro_q;
`ifdef ANULAR_ITEM_EN
    last_preco_n = last_preco;
    last_peso_n  = last_peso;
    undo_ok_n    = undo_ok;
`endif
    case (estado)
      ESPERA: begin
        taxa_lat_n = bus.pedido_taxa;
        if (bus.peso_balanca != '0) begin
          estado_n  = PESAGEM;
          cnt_n     = '0;
          amostra_n = bus.peso_balanca;
        end else if (bus.pedido_fim && num_q != '0) begin
          estado_n = TAXA;
        end
`ifdef ANULAR_ITEM_EN
        else if (bus.anular && num_q != '0 && undo_ok) begin
          preco_n    = last_preco;
          peso_n     = last_peso;
          subtrair_n = 1'b1;
          num_n      = num_q - IW'(1);
          undo_ok_n  = 1'b0;
        end
`endif
      end
      PESAGEM: begin
        amostra_n = bus.peso_balanca;
        if (bus.peso_balanca == '0) begin
          estado_n = ESPERA;
        end else if (bus.peso_balanca != amostra) begin
          cnt_n = '0;
        end else if (cnt == CW'(ESTAVEL_CICLOS - 1)) begin
          // A full purchase leaves the item on the pan unregistered until it is removed.
          if (num_q == IW'(MAX_ITENS)) begin
            erro_n   = 1'b1;
            estado_n = RETIRADA;
          end else begin
            item_preco_n = bus.preco_unitario;
            item_peso_n  = bus.peso_balanca;
            estado_n     = REGISTO;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      REGISTO: begin
        preco_n  = item_preco;
        peso_n   = item_peso;
        num_n    = num_q + IW'(1);
        estado_n = RETIRADA;
`ifdef ANULAR_ITEM_EN
        last_preco_n = item_preco;
        last_peso_n  = item_peso;
        undo_ok_n    = 1'b1;
`endif
      end
      RETIRADA: begin
        if (bus.peso_balanca == '0) estado_n = ESPERA;
      end
      TAXA: begin
        taxa_n   = taxa_lat;
        timer_n  = '0;
        estado_n = FIM;
      end
      FIM: begin
        fim_n = 1'b1;
        if (bus.emissao_talao) begin
          estado_n = LIMPEZA;
        end else if (timer == TW'(TALAO_TIMEOUT - 1)) begin
          erro_n   = 1'b1;
          estado_n = LIMPEZA;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      LIMPEZA: begin
        limpar_n   = 1'b1;
        num_n      = '0;
        taxa_n     = 1'b0;
        taxa_lat_n = 1'b0;
        erro_n     = 1'b0;
        estado_n   = ESPERA;
`ifdef ANULAR_ITEM_EN
        undo_ok_n  = 1'b0;
`endif
      end
      default: estado_n = ESPERA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      estado     <= ESPERA;
      cnt        <= '0;
      timer      <= '0;
      amostra    <= '0;
      item_preco <= '0;
      item_peso  <= '0;
      taxa_lat   <= 1'b0;
      preco_q    <= '0;
      peso_q     <= '0;
      subtrair_q <= 1'b0;
      taxa_q     <= 1'b0;
      fim_q      <= 1'b0;
      limpar_q   <= 1'b0;
      num_q      <= '0;
      erro_q     <= 1'b0;
`ifdef ANULAR_ITEM_EN
      last_preco <= '0;
      last_peso  <= '0;
      undo_ok    <= 1'b0;
`endif
    end else begin
      estado     <= estado_n;
      cnt        <= cnt_n;
      timer      <= timer_n;
      amostra    <= amostra_n;
      item_preco <= item_preco_n;
      item_peso  <= item_peso_n;
      taxa_lat   <= taxa_lat_n;
      preco_q    <= preco_n;
      peso_q     <= peso_n;
      subtrair_q <= subtrair_n;
      taxa_q     <= taxa_n;
      fim_q      <= fim_n;
      limpar_q   <= limpar_n;
      num_q      <= num_n;
      erro_q     <= erro_n;
`ifdef ANULAR_ITEM_EN
      last_preco <= last_preco_n;
      last_peso  <= last_peso_n;
      undo_ok    <= undo_ok_n;
`endif
    end
  end

  assign bus.preco_produto = preco_q;
  assign bus.peso_produto  = peso_q;
  assign bus.subtrair      = subtrair_q;
  assign bus.taxa          = taxa_q;
  assign bus.fim_compra    = fim_q;
  assign bus.limpar        = limpar_q;
  assign bus.num_itens     = num_q;
  assign bus.erro          = erro_q;

endmodule
